fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end of the kianv 5-stage pipeline.
- Owns the PC and drives the word address of the synchronous-read instruction ROM (1-cycle read latency, no read enable).
- Pairs each returned word with its PC and hands it to decode over a valid/ready handshake.
- Stalls by re-presenting the same ROM address, so no skid buffer is needed. Applies branch/jump redirects from later stages and flags misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000: byte address of the first instruction fetched after reset; bits [1:0] must be 0.
- IMEM_DEPTH, 64: ROM depth in 32-bit words; word addresses >= IMEM_DEPTH raise a fetch fault.

Ports:
- clk  in  1  pipeline clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- imem_raddr  out  30  ROM word address (byte PC [31:2]), combinational.
- imem_rdata  in  32  ROM data for the address presented on the previous cycle.
- redirect_valid  in  1  change control flow this cycle.
- redirect_pc  in  32  byte target of the redirect.
- out_valid  out  1  instruction/PC valid for decode.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  byte PC of out_instr.
- out_pc_plus4  out  32  out_pc + 4.
- fetch_fault  out  1  sticky fault flag.
- fault_pc  out  32  offending byte PC, captured on the first fault.

Behaviour:
- State:
  - req_pc (32 b): PC whose read is in flight.
  - inflight_v (1 b).
  - fault (1 b).
  - fault_pc_q (32 b).
- Async reset values: req_pc = RESET_PC, inflight_v = 0, fault = 0, fault_pc_q = 0. Outputs during and after reset: out_valid = 0, fetch_fault = 0, fault_pc = 0.
- fire = out_valid & out_ready.
- out_valid = inflight_v & ~redirect_valid & ~fault.
- out_instr = imem_rdata; out_pc = req_pc; out_pc_plus4 = req_pc + 4. All combinational and stable while out_valid is high and out_ready is low.
- imem_raddr priority:
  1. redirect_valid: redirect_pc[31:2].
  2. fire: (req_pc + 4)[31:2].
  3. Otherwise: req_pc[31:2] (re-read, so imem_rdata holds the same word next cycle).
- Next state, same priority:
  - Redirect: req_pc <= redirect_pc; inflight_v <= 1.
  - Fire: req_pc <= req_pc + 4.
  - Otherwise: hold. inflight_v <= 1 after the first cycle out of reset.
- Boot: the first cycle after reset deassertion presents RESET_PC; out_valid rises on the next cycle with imem_rdata = ROM[RESET_PC>>2]. This is 1 cycle of bubble.
- Redirect and fire in the same cycle: redirect wins and the current word is killed (out_valid is 0, so there is no fire).
- Redirect during a stall: same behaviour, with the target presented immediately.
- PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is allowed.
- Faults:
  - Triggers:
    - Accepted redirect with redirect_pc[1:0] != 0.
    - Next req_pc whose word index >= IMEM_DEPTH.
  - On trigger: fault <= 1 and fault_pc_q <= offending PC, first fault only.
  - While faulted: out_valid = 0, req_pc frozen, imem_raddr = req_pc[31:2].
  - Only rst clears a fault; redirects are ignored while faulted.
- Reset mid-stall or mid-redirect: all state returns to the reset values asynchronously; no in-flight word is delivered.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds outputs perf_fetched (32 b) and perf_stall (32 b).
  - perf_fetched counts fire cycles.
  - perf_stall counts cycles with out_valid & ~out_ready.
  - Both reset to 0, wrap at 2^32, and freeze while faulted.
- When undefined, neither port nor the counter logic exists.

Test Plan:
- Reset release, ROM word i = 32'h1000_0000 + i, out_ready = 1 throughout:
  - cycle 0: imem_raddr = 0, out_valid = 0;
  - cycle 1: out_pc = 0, out_instr = 32'h1000_0000;
  - cycle 2: out_pc = 4, out_instr = 32'h1000_0001;
  - one instruction per cycle thereafter.
- Stall: drop out_ready for 3 cycles with out_pc = 8:
  - out_pc = 8 and out_instr = 32'h1000_0002 stay stable;
  - imem_raddr = 2 each stalled cycle;
  - after release, out_pc = 12 follows with no duplicate and no skip.
- Redirect to 32'h20 while out_pc = 4 is presented:
  - that cycle out_valid = 0 and imem_raddr = 8;
  - next cycle out_pc = 32'h20, out_instr = 32'h1000_0008.
- Redirect and fire together, with out_ready = 1 and redirect_pc = 32'h40: PC 4 is never accepted and the next output is PC 32'h40.
- Misaligned redirect_pc = 32'h22:
  - next cycle fetch_fault = 1, fault_pc = 32'h22, out_valid = 0;
  - a further redirect to 0 is ignored;
  - only rst clears the fault.
- Sequential fetch reaching PC 4*IMEM_DEPTH = 32'h100 (IMEM_DEPTH = 64):
  - the last valid out_pc is 32'hFC;
  - then fetch_fault = 1 with fault_pc = 32'h100.
  - With FETCH_PERF_CNT_EN defined, perf_fetched = 64 at that point.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the sync-read ROM address and
// hands {instr, pc} to decode over valid/ready. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] imem_raddr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] raddr_pc;
  logic [31:0] pc_plus4;
  logic        fire;
  logic        redir_bad;
  logic        seq_oob;

  assign pc_plus4     = req_pc_q + 32'd4;
  assign out_valid    = inflight_q & ~redirect_valid & ~fault_q;
  assign fire         = out_valid & out_ready;
  assign out_instr    = imem_rdata;
  assign out_pc       = req_pc_q;
  assign out_pc_plus4 = pc_plus4;
  assign fetch_fault  = fault_q;
  assign fault_pc     = fault_pc_q;
  assign imem_raddr   = raddr_pc[31:2];

  assign redir_bad = (redirect_pc[1:0] != 2'b00) ||
                     ({2'b00, redirect_pc[31:2]} >= IMEM_DEPTH);
  assign seq_oob   = ({2'b00, pc_plus4[31:2]} >= IMEM_DEPTH);

  // Stalls re-present req_pc so the ROM keeps returning the same word.
  always_comb begin
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    raddr_pc   = req_pc_q;
    if (!fault_q) begin
      inflight_d = 1'b1;
      if (redirect_valid) begin
        raddr_pc = redirect_pc;
        if (redir_bad) begin
          fault_d    = 1'b1;
          fault_pc_d = redirect_pc;
        end else begin
          req_pc_d = redirect_pc;
        end
      end else if (fire) begin
        raddr_pc = pc_plus4;
        if (seq_oob) begin
          fault_d    = 1'b1;
          fault_pc_d = pc_plus4;
        end else begin
          req_pc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else if (!fault_q) begin
      if (fire)                   perf_fetched_q <= perf_fetched_q + 32'd1;
      if (out_valid & ~out_ready) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage against a PC-stream reference model;
// ROM word i holds 32'h1000_0000 + i.
module tb_fetch_stage;
  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: the PC of the word decode currently sees, plus fault bookkeeping.
  logic [31:0] m_pc;
  bit          m_have;
  bit          m_fault;
  logic [31:0] m_fault_pc;
  int unsigned m_fetched;
  int unsigned m_stall;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_raddr    (imem_raddr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4),
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= 32'h1000_0000 + {2'b00, imem_raddr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_have     = 1'b0;
    m_fault    = 1'b0;
    m_fault_pc = 32'h0;
    m_fetched  = 0;
    m_stall    = 0;
  endtask

  function automatic bit out_of_rom(input logic [31:0] pc);
    return (pc / 4) >= DEPTH;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_raddr", {2'b00, imem_raddr}, 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit          exp_valid;
    bit          exp_fire;
    logic [31:0] exp_addr_pc;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    exp_valid = m_have && !rv && !m_fault;
    exp_fire  = exp_valid && rdy;
    if (m_fault)       exp_addr_pc = m_pc;
    else if (rv)       exp_addr_pc = rpc;
    else if (exp_fire) exp_addr_pc = m_pc + 32'd4;
    else               exp_addr_pc = m_pc;
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    chk("imem_raddr", {2'b00, imem_raddr}, exp_addr_pc / 4);
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    chk("fault_pc", fault_pc, m_fault_pc);
    if (exp_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_instr", out_instr, 32'h1000_0000 + m_pc / 4);
      chk("out_pc_plus4", out_pc_plus4, m_pc + 32'd4);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
`endif
    if (!m_fault) begin
      if (rv) begin
        if (rpc[1:0] != 2'b00 || out_of_rom(rpc)) begin
          m_fault = 1'b1; m_fault_pc = rpc;
        end else begin
          m_pc = rpc; m_have = 1'b1;
        end
      end else if (exp_fire) begin
        m_fetched++;
        if (out_of_rom(m_pc + 32'd4)) begin
          m_fault = 1'b1; m_fault_pc = m_pc + 32'd4;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else begin
        if (exp_valid) m_stall++;
        m_have = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Boot, stream, 3-cycle stall at PC 8, then continue; reset lands mid-stall.
    repeat (3) step(1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    do_reset();

    // Redirect to 0x20 while PC 4 is presented, then redirect+ready to 0x40.
    repeat (2) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h20, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h40, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h10, 1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1);

    // Misaligned redirect faults; later redirects are ignored until reset.
    step(1'b1, 32'h22, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1);
    chk("misalign_fault_pc", fault_pc, 32'h22);
    do_reset();
    step(1'b0, 32'h0, 1'b1);

    // Run off the end of the ROM.
    do_reset();
    repeat (70) step(1'b0, 32'h0, 1'b1);
    chk("oob_fault", {31'b0, fetch_fault}, 32'h1);
    chk("oob_fault_pc", fault_pc, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("oob_perf_fetched", perf_fetched, 32'd64);
`endif

    // Random ready/redirect traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit          rv;
      bit          rdy;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom_range(0, DEPTH - 1) * 4;
      if ($urandom_range(0, 49) == 0) rpc = rpc | 32'h2;
      step(rv, rpc, rdy);
      if (m_fault && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
